// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-outstanding memory port.
// Ports: req0/req1 request+response channels, shared resp_rdata, sel, mem_* port.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic              resp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic              resp1_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sel,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] tcnt;

  logic accept;
  logic hit;
  logic expire;
  logic done;

  always_comb begin
    mem_valid = (state == ISSUE);
    accept    = mem_valid & mem_ready;
    hit       = (state == WAIT) & mem_resp_valid;
    // A response arriving on the last allowed cycle wins over the timeout.
    expire    = (state == WAIT) & ~mem_resp_valid & (tcnt == TLAST);
    done      = hit | expire;
  end

  assign mem_addr  = sel ? req1_addr  : req0_addr;
  assign mem_we    = sel ? req1_we    : req0_we;
  assign mem_wdata = sel ? req1_wdata : req0_wdata;

  assign req0_ready  = accept & ~sel;
  assign req1_ready  = accept &  sel;
  assign resp0_valid = done   & ~sel;
  assign resp1_valid = done   &  sel;
  assign resp0_err   = expire & ~sel;
  assign resp1_err   = expire &  sel;
  assign resp_rdata  = hit ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            // On a tie the port not served last time goes next.
            if (req0_valid & req1_valid)
              sel <= ~last;
            else
              sel <= req1_valid;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            tcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            last  <= sel;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_we, req0_ready, resp0_valid, resp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_we, req1_ready, resp1_valid, resp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [DW-1:0] resp_rdata;
  logic          sel, mem_valid, mem_we, mem_ready, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_err(resp1_err),
    .resp_rdata(resp_rdata), .sel(sel),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: is a transaction open, has memory taken it,
  // who owns it, who finished last, and how many cycles it has waited.
  bit busy, taken, owner, prev;
  int waited;
  bit owed0, owed1;
  bit rdy0_seen, rdy1_seen, acc_seen;
  int grants[$];

  always @(negedge clk) begin
    bit e_acc, e_resp, e_tmo, e_done;
    logic [7:0] act, exp;
    act = {mem_valid, sel, req0_ready, req1_ready,
           resp0_valid, resp0_err, resp1_valid, resp1_err};
    if (rst) begin
      check("reset_outs", act, 8'h00);
      busy = 0; taken = 0; owner = 0; prev = 1; waited = 0;
      owed0 = 0; owed1 = 0;
      rdy0_seen = 0; rdy1_seen = 0; acc_seen = 0;
    end else begin
      e_acc  = busy && !taken && mem_ready;
      e_resp = busy && taken && mem_resp_valid;
      // This is the TO-th cycle spent waiting and nothing came back.
      e_tmo  = busy && taken && !mem_resp_valid && (waited + 1 == TO);
      e_done = e_resp || e_tmo;
      exp = {busy && !taken, owner,
             e_acc && !owner, e_acc && owner,
             e_done && !owner, e_tmo && !owner,
             e_done && owner, e_tmo && owner};
      check("outs", act, exp);
      if (busy && !taken) begin
        check("mem_addr", mem_addr, owner ? req1_addr : req0_addr);
        check("mem_we", mem_we, owner ? req1_we : req0_we);
        check("mem_wdata", mem_wdata, owner ? req1_wdata : req0_wdata);
      end
      if (e_done)
        check("resp_rdata", resp_rdata, e_resp ? mem_rdata : '0);
      if (owed0) check("proto0_hold", req0_valid, 1'b1);
      if (owed1) check("proto1_hold", req1_valid, 1'b1);
      owed0 = req0_valid && !req0_ready;
      owed1 = req1_valid && !req1_ready;
      rdy0_seen = req0_ready;
      rdy1_seen = req1_ready;
      acc_seen  = mem_valid && mem_ready;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (!busy) begin
        if (req0_valid || req1_valid) begin
          busy  = 1;
          owner = (req0_valid && req1_valid) ? !prev : req1_valid;
        end
      end else if (!taken) begin
        if (mem_ready) begin taken = 1; waited = 0; end
      end else if (e_done) begin
        busy = 0; taken = 0; prev = owner;
      end else begin
        waited++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory answers one cycle after accepting; requesters either re-request
  // immediately (hold) or drop once served.
  task automatic auto_cycles(input int n, input bit hold0, input bit hold1);
    for (int i = 0; i < n; i++) begin
      cyc();
      mem_ready      = 1'b1;
      mem_resp_valid = acc_seen;
      mem_rdata      = $urandom;
      if (rdy0_seen) begin req0_valid = hold0; req0_addr = $urandom; end
      if (rdy1_seen) begin req1_valid = hold1; req1_addr = $urandom; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, err;
    int w;
    bit pend;
    int lat;
    rst = 1; mem_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    req0_valid = 0; req0_addr = '0; req0_we = 0; req0_wdata = '0;
    req1_valid = 0; req1_addr = '0; req1_we = 0; req1_wdata = '0;
    repeat (2) cyc();
    rst = 0;

    // 1: single read on port 0
    cyc();
    req0_valid = 1; req0_addr = 32'h100; req0_we = 0; mem_ready = 1;
    #1 check("t1_idle_mv", mem_valid, 1'b0);
    check("t1_idle_rdy", req0_ready, 1'b0);
    cyc();
    #1 check("t1_sel", sel, 1'b0);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_rdy", req0_ready, 1'b1);
    cyc();
    req0_valid = 0; mem_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hDEADBEEF;
    #1 check("t1_resp", {resp0_valid, resp0_err, resp1_valid}, 3'b100);
    check("t1_rdata", resp_rdata, 32'hDEADBEEF);
    cyc();
    mem_resp_valid = 0;
    #1 check("t1_after", resp0_valid, 1'b0);

    // 2: both requesting from reset alternate 0,1,0,1
    rst = 1; req0_valid = 1; req1_valid = 1;
    grants.delete();
    cyc();
    rst = 0;
    auto_cycles(16, 1, 1);
    check("t2_ngrants", grants.size() >= 4, 1'b1);
    if (grants.size() >= 4) begin
      check("t2_g0", grants[0], 0);
      check("t2_g1", grants[1], 1);
      check("t2_g2", grants[2], 0);
      check("t2_g3", grants[3], 1);
    end
    auto_cycles(12, 0, 0);

    // 3: port 1 write with slow memory accept
    cyc();
    mem_ready = 0; mem_resp_valid = 0;
    req1_valid = 1; req1_addr = 32'h20; req1_we = 1; req1_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1 check("t3_hold", {mem_valid, mem_we, req1_ready}, 3'b110);
      check("t3_wdata", mem_wdata, 32'h55);
    end
    cyc();
    mem_ready = 1;
    #1 check("t3_accept", {mem_valid, req1_ready, req0_ready}, 3'b110);
    cyc();
    req1_valid = 0; req1_we = 0; mem_ready = 0; mem_resp_valid = 1;
    #1 check("t3_resp", {resp1_valid, resp1_err}, 2'b10);

    // 4: timeout after exactly TO cycles waiting, late response dropped
    cyc();
    mem_resp_valid = 0; req0_valid = 1; req0_addr = 32'h40;
    cyc();
    mem_ready = 1;
    #1 check("t4_rdy", req0_ready, 1'b1);
    cyc();
    req0_valid = 0; mem_ready = 0;
    got = 0; w = 0; err = 0;
    for (int i = 1; i <= TO + 4 && !got; i++) begin
      if (i > 1) cyc();
      #1;
      if (resp0_valid) begin got = 1; w = i; err = resp0_err; end
    end
    check("t4_got", got, 1'b1);
    check("t4_cycles", w, TO);
    check("t4_err", err, 1'b1);
    cyc();
    mem_resp_valid = 1; mem_rdata = 32'h1234;
    #1 check("t4_late", {resp0_valid, resp1_valid}, 2'b00);
    cyc();
    mem_resp_valid = 0;

    // 5: reset in WAIT and in ISSUE, then tie goes to port 0
    req1_valid = 1; req1_addr = 32'h80;
    cyc();
    mem_ready = 1;
    #1 check("t5_rdy1", req1_ready, 1'b1);
    cyc();
    req1_valid = 0; mem_ready = 0;
    #1 check("t5_sel_wait", sel, 1'b1);
    cyc();
    rst = 1;
    #1 check("t5_rst_wait", {mem_valid, sel, resp1_valid}, 3'b000);
    cyc();
    rst = 0; req1_valid = 1;
    cyc();
    #1 check("t5_issue", {mem_valid, sel}, 2'b11);
    cyc();
    rst = 1; req0_valid = 1;
    #1 check("t5_rst_issue", {mem_valid, sel}, 2'b00);
    cyc();
    rst = 0;
    cyc();
    mem_ready = 1;
    #1 check("t5_tie", {sel, req0_ready, req1_ready}, 3'b010);
    auto_cycles(12, 0, 0);

    // 6: response and new request in the same cycle
    cyc();
    mem_ready = 0; mem_resp_valid = 0; req0_valid = 1; req0_addr = 32'hC0;
    cyc();
    mem_ready = 1;
    #1 check("t6_rdy0", req0_ready, 1'b1);
    cyc();
    req0_valid = 0; mem_ready = 0;
    cyc();
    mem_resp_valid = 1; mem_rdata = 32'hA5A5; req1_valid = 1; req1_addr = 32'hE0;
    #1 check("t6_resp", {resp0_valid, mem_valid, req1_ready}, 3'b100);
    cyc();
    mem_resp_valid = 0;
    #1 check("t6_idle", mem_valid, 1'b0);
    cyc();
    mem_ready = 1;
    #1 check("t6_issue", {mem_valid, sel, req1_ready}, 3'b111);
    check("t6_addr", mem_addr, 32'hE0);
    cyc();
    req1_valid = 0; mem_ready = 0; mem_resp_valid = 1;
    #1 check("t6_resp1", resp1_valid, 1'b1);
    cyc();
    mem_resp_valid = 0;

    // Random traffic against the model
    pend = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst = ($urandom_range(0, 399) == 0);
      if (!req0_valid || rdy0_seen || rst) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr = $urandom; req0_we = $urandom; req0_wdata = $urandom;
      end
      if (!req1_valid || rdy1_seen || rst) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr = $urandom; req1_we = $urandom; req1_wdata = $urandom;
      end
      mem_ready = $urandom;
      mem_rdata = $urandom;
      if (acc_seen) begin pend = 1; lat = $urandom_range(0, TO + 2); end
      mem_resp_valid = 0;
      if (pend) begin
        if (lat == 0) begin mem_resp_valid = 1; pend = 0; end
        else lat--;
      end else if ($urandom_range(0, 39) == 0) begin
        mem_resp_valid = 1;
      end
      if (rst) pend = 0;
    end
    cyc();
    rst = 0;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
